// File: rtl/mix_slot_sequencer.sv
// Per-sample frame scheduler: sweeps the {voice, osc, env} slot index once per
// tick, emits osc/voice pipeline strobes, drains, then pulses frame_done.
module mix_slot_sequencer #(
  parameter int VOICES       = 8,
  parameter int V_OSC        = 4,
  parameter int O_ENVS       = 2,
  parameter int V_WIDTH      = 3,
  parameter int O_WIDTH      = 2,
  parameter int OE_WIDTH     = 1,
  parameter int E_WIDTH      = O_WIDTH + OE_WIDTH,
  parameter int OSC_STAGES   = 4,
  parameter int VOICE_STAGES = 3,
  parameter int DRAIN_CYC    = 4
) (
  input  logic                       sCLK_XVXENVS,
  input  logic                       iRST,
  input  logic                       iSAMPLE_TICK,
  input  logic                       enable,
  input  logic                       clr_overrun,
  output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  output logic                       xxxx_zero,
  output logic [OSC_STAGES-1:0]      osc_stb,
  output logic [VOICE_STAGES-1:0]    voice_stb,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  output logic [15:0]                frame_cnt
);

  localparam int SLOTS = VOICES * V_OSC * O_ENVS;
  localparam int SW    = V_WIDTH + E_WIDTH;
  localparam int DW    = $clog2(DRAIN_CYC + 1);

  // The drain window must cover the deepest strobe pipeline.
  if (DRAIN_CYC < OSC_STAGES || DRAIN_CYC < VOICE_STAGES) begin : g_drain_too_short
    $error("DRAIN_CYC must be >= max(OSC_STAGES, VOICE_STAGES)");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [SW-1:0]           xxxx_nxt;
  logic [DW-1:0]           drain_cnt, drain_nxt;
  logic                    last_slot, last_drain;
  logic                    osc_s0, voice_s0;
  logic [OSC_STAGES-2:0]   osc_dly;
  logic [VOICE_STAGES-2:0] voice_dly;

  assign last_slot  = (xxxx == SW'(SLOTS - 1));
  assign last_drain = (drain_cnt == DW'(DRAIN_CYC - 1));

  assign frame_done = (state == DRAIN) && last_drain;
  assign xxxx_zero  = (state == RUN) && (xxxx == '0);
  assign osc_s0     = (state == RUN) && (xxxx[OE_WIDTH-1:0] == '0);
  assign voice_s0   = (state == RUN) && (xxxx[E_WIDTH-1:0] == '0);
  assign osc_stb    = {osc_dly, osc_s0};
  assign voice_stb  = {voice_dly, voice_s0};

  always_comb begin
    state_nxt = state;
    xxxx_nxt  = '0;
    drain_nxt = '0;
    case (state)
      IDLE:  if (iSAMPLE_TICK && enable) state_nxt = RUN;
      RUN: begin
        if (last_slot) state_nxt = DRAIN;
        else           xxxx_nxt  = xxxx + SW'(1);
      end
      DRAIN: begin
        if (last_drain) state_nxt = IDLE;
        else            drain_nxt = drain_cnt + DW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    if (iRST) begin
      state     <= IDLE;
      xxxx      <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
      osc_dly   <= '0;
      voice_dly <= '0;
    end else begin
      state     <= state_nxt;
      xxxx      <= xxxx_nxt;
      drain_cnt <= drain_nxt;
      busy      <= (state_nxt != IDLE);
      // A lost tick outranks a simultaneous clear.
      if (iSAMPLE_TICK && state != IDLE) overrun <= 1'b1;
      else if (clr_overrun)              overrun <= 1'b0;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      osc_dly[0]   <= osc_s0;
      voice_dly[0] <= voice_s0;
      for (int k = 1; k < OSC_STAGES - 1; k++)   osc_dly[k]   <= osc_dly[k-1];
      for (int k = 1; k < VOICE_STAGES - 1; k++) voice_dly[k] <= voice_dly[k-1];
    end
  end

endmodule

// File: tb/tb_mix_slot_sequencer.sv
// Directed bench for mix_slot_sequencer: frame timing, strobes, tick rules,
// enable gating, mid-frame reset and back-to-back frames.
module tb_mix_slot_sequencer;

  logic        clk = 1'b0;
  logic        iRST = 1'b1;
  logic        iSAMPLE_TICK = 1'b0;
  logic        enable = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [5:0]  xxxx;
  logic        xxxx_zero;
  logic [3:0]  osc_stb;
  logic [2:0]  voice_stb;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mix_slot_sequencer dut (
    .sCLK_XVXENVS (clk),
    .iRST         (iRST),
    .iSAMPLE_TICK (iSAMPLE_TICK),
    .enable       (enable),
    .clr_overrun  (clr_overrun),
    .xxxx         (xxxx),
    .xxxx_zero    (xxxx_zero),
    .osc_stb      (osc_stb),
    .voice_stb    (voice_stb),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .frame_cnt    (frame_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe-0 patterns, r = cycles since the tick (slot r-1 shown in RUN).
  function automatic logic osc0(input int r);
    return (r >= 1) && (r <= 64) && (((r - 1) % 2) == 0);
  endfunction

  function automatic logic voice0(input int r);
    return (r >= 1) && (r <= 64) && (((r - 1) % 8) == 0);
  endfunction

  task automatic check_quiet(input string tag, input logic [15:0] fcnt);
    check_eq({tag, " xxxx"}, 32'(xxxx), 32'd0);
    check_eq({tag, " zero"}, 32'(xxxx_zero), 32'd0);
    check_eq({tag, " osc"}, 32'(osc_stb), 32'd0);
    check_eq({tag, " voice"}, 32'(voice_stb), 32'd0);
    check_eq({tag, " busy"}, 32'(busy), 32'd0);
    check_eq({tag, " done"}, 32'(frame_done), 32'd0);
    check_eq({tag, " fcnt"}, 32'(frame_cnt), 32'(fcnt));
  endtask

  // Tick in the current cycle T, then check every cycle T+1..T+69.
  // Extra ticks at rel tick2/tick3 (0 = none); enable dropped at en_drop.
  task automatic run_frame(input string name, input int tick2, input int tick3,
                           input int en_drop, input logic [15:0] fcnt0, input logic ov0);
    logic [3:0] exp_osc;
    logic [2:0] exp_voice;
    logic       exp_ov;
    iSAMPLE_TICK = 1'b1;
    enable = 1'b1;
    step();
    for (int rel = 1; rel <= 69; rel++) begin
      iSAMPLE_TICK = (rel == tick2) || (rel == tick3);
      if (rel == en_drop) enable = 1'b0;
      for (int k = 0; k < 4; k++) exp_osc[k] = osc0(rel - k);
      for (int k = 0; k < 3; k++) exp_voice[k] = voice0(rel - k);
      exp_ov = ov0 || (tick2 != 0 && rel > tick2) || (tick3 != 0 && rel > tick3);
      check_eq($sformatf("%s r%0d xxxx", name, rel), 32'(xxxx),
               (rel <= 64) ? 32'(rel - 1) : 32'd0);
      check_eq($sformatf("%s r%0d zero", name, rel), 32'(xxxx_zero), 32'(rel == 1));
      check_eq($sformatf("%s r%0d osc", name, rel), 32'(osc_stb), 32'(exp_osc));
      check_eq($sformatf("%s r%0d voice", name, rel), 32'(voice_stb), 32'(exp_voice));
      check_eq($sformatf("%s r%0d busy", name, rel), 32'(busy), 32'(rel <= 68));
      check_eq($sformatf("%s r%0d done", name, rel), 32'(frame_done), 32'(rel == 68));
      check_eq($sformatf("%s r%0d fcnt", name, rel), 32'(frame_cnt),
               (rel == 69) ? 32'(fcnt0 + 16'd1) : 32'(fcnt0));
      check_eq($sformatf("%s r%0d ovr", name, rel), 32'(overrun), 32'(exp_ov));
      if (rel < 69) step();
    end
    iSAMPLE_TICK = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check_quiet("rst", 16'd0);
    check_eq("rst ovr", 32'(overrun), 32'd0);
    iRST = 1'b0;
    step();
    check_quiet("idle", 16'd0);

    // Plain frame
    run_frame("f1", 0, 0, 0, 16'd0, 1'b0);

    // Lost ticks mid-frame and on the frame_done cycle, then clear
    run_frame("ovr", 30, 68, 0, 16'd1, 1'b0);
    repeat (11) step();
    check_eq("ovr hold r80", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check_eq("ovr clr r81", 32'(overrun), 32'd0);

    // Ticks while idle and disabled are ignored
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iSAMPLE_TICK = 1'b1;
      step();
      iSAMPLE_TICK = 1'b0;
      step();
      check_quiet($sformatf("dis%0d", i), 16'd2);
      check_eq($sformatf("dis%0d ovr", i), 32'(overrun), 32'd0);
    end

    // Dropping enable mid-frame lets the frame finish
    run_frame("endrop", 0, 0, 10, 16'd2, 1'b0);

    // Reset mid-frame aborts without frame_done
    step();
    iSAMPLE_TICK = 1'b1;
    enable = 1'b1;
    step();
    iSAMPLE_TICK = 1'b0;
    repeat (19) step();
    check_eq("mrst r20 xxxx", 32'(xxxx), 32'd19);
    check_eq("mrst r20 busy", 32'(busy), 32'd1);
    iRST = 1'b1;
    step();
    check_quiet("mrst r21", 16'd0);
    iRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet($sformatf("mrst post%0d", i), 16'd0);
    end
    run_frame("clean", 0, 0, 0, 16'd0, 1'b0);

    // Back-to-back: second tick lands on the first idle cycle
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    step();
    run_frame("b2b0", 0, 0, 0, 16'd0, 1'b0);
    run_frame("b2b1", 0, 0, 0, 16'd1, 1'b0);
    check_eq("b2b fcnt", 32'(frame_cnt), 32'd2);
    check_eq("b2b ovr", 32'(overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
